// File: rtl/lv_fv_pkg.sv
// Shared types for the LV/FV/DV timing generator: pattern modes, FSM states, bar count.
package lv_fv_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_HRAMP = 2'd1,
    MODE_VRAMP = 2'd2,
    MODE_BARS  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ACT  = 3'd2,
    ST_HBL  = 3'd3,
    ST_POST = 3'd4,
    ST_VBL  = 3'd5
  } state_e;

  localparam int BAR_COUNT = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lv_fv_pattern.sv
// Maps (mode, h_cnt, v_cnt, solid) to a CH*DW pixel; one registered stage, zero when not valid.
// No backpressure; an optional stamp value overrides the pattern on its cycle.
module lv_fv_pattern
  import lv_fv_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CH    = 3,
  parameter int H_ACT = 640,
  parameter int HW    = 10,
  parameter int VW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [1:0]       mode,
  input  logic [HW-1:0]    h_cnt,
  input  logic [VW-1:0]    v_cnt,
  input  logic [CH*DW-1:0] solid,
  input  logic             stamp_vld,
  input  logic [15:0]      stamp_dat,
  output logic [CH*DW-1:0] pix
);

  localparam int PW    = CH * DW;
  localparam int BAR_W = H_ACT / BAR_COUNT;

  logic [2:0]    bar;
  logic [DW-1:0] h_val;
  logic [DW-1:0] v_val;
  logic [PW-1:0] pat;
  logic [PW-1:0] pix_d;
  logic [PW-1:0] pix_q;

  assign bar   = 3'(h_cnt / HW'(BAR_W));
  assign h_val = DW'(h_cnt);
  assign v_val = DW'(v_cnt);

  // Bars cycle R/G/B weights: ch0 takes the MSB of the bar index, ch2 the LSB.
  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign pat[g*DW +: DW] =
        (mode == MODE_SOLID) ? solid[g*DW +: DW] :
        (mode == MODE_HRAMP) ? h_val :
        (mode == MODE_VRAMP) ? v_val :
                               {DW{bar[2-(g%3)]}};
  end

  always_comb begin
    pix_d = '0;
    if (vld) begin
      pix_d = stamp_vld ? PW'(stamp_dat) : pat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix = pix_q;

endmodule

// File: rtl/lv_fv_gen.sv
// LV/FV/DV video timing and test-pattern source; LV_FV_GEN_FRAME_STAMP_EN puts frame_cnt on each sof pixel.
// All outputs registered, no backpressure; en is honoured only in IDLE and at the end of vertical blanking.
module lv_fv_gen
  import lv_fv_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CH      = 3,
  parameter int H_ACT   = 640,
  parameter int H_BLANK = 160,
  parameter int V_ACT   = 480,
  parameter int FV_PRE  = 4,
  parameter int FV_POST = 4,
  parameter int V_BLANK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CH*DW-1:0] solid,
  output logic [CH*DW-1:0] pix,
  output logic             fv,
  output logic             lv,
  output logic             dv,
  output logic             sof,
  output logic             eol,
  output logic [15:0]      frame_cnt
);

  localparam int PW      = CH * DW;
  localparam int CNT_MAX = max_int(max_int(H_ACT, H_BLANK),
                                   max_int(max_int(FV_PRE, FV_POST), V_BLANK));
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int VW      = $clog2(V_ACT + 1);

  localparam logic [CW-1:0] H_LAST    = CW'(H_ACT - 1);
  localparam logic [CW-1:0] HBL_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(FV_PRE - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(FV_POST - 1);
  localparam logic [CW-1:0] VBL_LAST  = CW'(V_BLANK - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_ACT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] solid_q, solid_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          fv_q, fv_d;
  logic          lv_q, lv_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          stamp_vld;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    v_d         = v_q;
    mode_d      = mode_q;
    solid_d     = solid_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        v_d   = '0;
        if (en) begin
          state_d = ST_PRE;
          mode_d  = mode;
          solid_d = solid;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_ACT;
          cnt_d   = '0;
          v_d     = '0;
        end
      end
      ST_ACT: begin
        if (cnt_q == H_LAST) begin
          cnt_d   = '0;
          state_d = (v_q == V_LAST) ? ST_POST : ST_HBL;
        end
      end
      ST_HBL: begin
        if (cnt_q == HBL_LAST) begin
          state_d = ST_ACT;
          cnt_d   = '0;
          v_d     = v_q + VW'(1);
        end
      end
      ST_POST: begin
        if (cnt_q == POST_LAST) begin
          state_d     = ST_VBL;
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ST_VBL: begin
        if (cnt_q == VBL_LAST) begin
          cnt_d = '0;
          if (en) begin
            state_d = ST_PRE;
            mode_d  = mode;
            solid_d = solid;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line up with it.
    fv_d  = state_d inside {ST_PRE, ST_ACT, ST_HBL, ST_POST};
    lv_d  = (state_d == ST_ACT);
    sof_d = lv_d && (cnt_d == '0) && (v_d == '0);
    eol_d = lv_d && (cnt_d == H_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      v_q         <= '0;
      mode_q      <= '0;
      solid_q     <= '0;
      frame_cnt_q <= '0;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      solid_q     <= solid_d;
      frame_cnt_q <= frame_cnt_d;
      fv_q        <= fv_d;
      lv_q        <= lv_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
    end
  end

`ifdef LV_FV_GEN_FRAME_STAMP_EN
  assign stamp_vld = sof_d;
`else
  assign stamp_vld = 1'b0;
`endif

  lv_fv_pattern #(
    .DW    (DW),
    .CH    (CH),
    .H_ACT (H_ACT),
    .HW    (CW),
    .VW    (VW)
  ) u_pattern (
    .clk       (clk),
    .rst       (rst),
    .vld       (lv_d),
    .mode      (mode_q),
    .h_cnt     (cnt_d),
    .v_cnt     (v_d),
    .solid     (solid_q),
    .stamp_vld (stamp_vld),
    .stamp_dat (frame_cnt_q),
    .pix       (pix)
  );

  assign fv        = fv_q;
  assign lv        = lv_q;
  assign dv        = lv_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lv_fv_gen.sv
// Directed bench for lv_fv_gen on an 8x3 frame: timing, patterns, en/mode latching, reset abort, stamp.
module tb_lv_fv_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] solid;
  logic [23:0] pix;
  logic        fv;
  logic        lv;
  logic        dv;
  logic        sof;
  logic        eol;
  logic [15:0] frame_cnt;

  int n_total;
  int n_bad;
  int cur_k;

  lv_fv_gen #(
    .DW(8), .CH(3), .H_ACT(8), .H_BLANK(2), .V_ACT(3),
    .FV_PRE(1), .FV_POST(1), .V_BLANK(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .solid     (solid),
    .pix       (pix),
    .fv        (fv),
    .lv        (lv),
    .dv        (dv),
    .sof       (sof),
    .eol       (eol),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, cur_k, got, exp);
    end
  endtask

  // Hand-derived pattern for the 8-pixel line: bar index equals h_cnt here.
  function automatic logic [23:0] exp_pat(input logic [1:0] m, input int h, input int ln,
                                          input logic [23:0] sol);
    case (m)
      2'd0:    return sol;
      2'd1:    return {3{8'(h)}};
      2'd2:    return {3{8'(ln)}};
      default: return {((h & 1) != 0) ? 8'hFF : 8'h00,
                       ((h & 2) != 0) ? 8'hFF : 8'h00,
                       ((h & 4) != 0) ? 8'hFF : 8'h00};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outputs(input logic e_fv, input logic e_lv, input logic e_sof,
                               input logic e_eol, input logic [23:0] e_pix,
                               input logic [15:0] e_fc);
    chk_val("fv",        32'(fv),        32'(e_fv));
    chk_val("lv",        32'(lv),        32'(e_lv));
    chk_val("dv",        32'(dv),        32'(e_lv));
    chk_val("sof",       32'(sof),       32'(e_sof));
    chk_val("eol",       32'(eol),       32'(e_eol));
    chk_val("pix",       32'(pix),       32'(e_pix));
    chk_val("frame_cnt", 32'(frame_cnt), 32'(e_fc));
  endtask

  // Entered at k=0 (first fv cycle); leaves at k=32. Frame layout:
  // k0 PRE, k1-8 line0, k9-10 HBL, k11-18 line1, k19-20 HBL, k21-28 line2, k29 POST, k30-31 VBL.
  task automatic run_frame(input logic [1:0] m, input logic [23:0] sol, input int fc0,
                           input int act_k, input logic [1:0] new_mode, input logic drop_en);
    int ln;
    int h;
    logic [23:0] e_pix;
    for (int k = 0; k < 32; k++) begin
      cur_k = k;
      ln = -1;
      h  = 0;
      if (k >= 1 && k <= 8) begin
        ln = 0; h = k - 1;
      end else if (k >= 11 && k <= 18) begin
        ln = 1; h = k - 11;
      end else if (k >= 21 && k <= 28) begin
        ln = 2; h = k - 21;
      end
      e_pix = (ln >= 0) ? exp_pat(m, h, ln, sol) : 24'h0;
`ifdef LV_FV_GEN_FRAME_STAMP_EN
      if (k == 1) e_pix = 24'(fc0);
`endif
      check_outputs(k < 30, ln >= 0, k == 1, (ln >= 0) && (h == 7), e_pix,
                    (k < 30) ? 16'(fc0) : 16'(fc0 + 1));
      if (k == act_k) begin
        if (drop_en) en = 1'b0;
        else         mode = new_mode;
      end
      step();
    end
  endtask

  task automatic check_idle(input int n, input logic [15:0] fc);
    for (int i = 0; i < n; i++) begin
      cur_k = 100 + i;
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, fc);
      step();
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cur_k   = -1;
    rst     = 1'b0;
    en      = 1'b0;
    mode    = 2'd0;
    solid   = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 16'd0);

    // Out of reset with en low the generator stays idle.
    rst = 1'b1;
    check_idle(3, 16'd0);

    en   = 1'b1;
    mode = 2'd1;
    step();
    run_frame(2'd1, 24'h0, 0, -1, 2'd0, 1'b0);
    run_frame(2'd1, 24'h0, 1, 15, 2'd3, 1'b0);
    run_frame(2'd3, 24'h0, 2, 5,  2'd2, 1'b0);
    run_frame(2'd2, 24'h0, 3, 12, 2'd0, 1'b1);
    check_idle(4, 16'd4);

    // Restart in bars mode, then reset in the middle of line 1 (k=14 is h_cnt 3).
    en    = 1'b1;
    mode  = 2'd3;
    solid = 24'h123456;
    step();
    repeat (14) step();
    cur_k = 14;
    chk_val("mid_lv",  32'(lv),  32'd1);
    chk_val("mid_pix", 32'(pix), 32'hFFFF00);
    rst = 1'b0;
    step();
    cur_k = 200;
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 16'd0);
    rst = 1'b1;
    step();
    run_frame(2'd3, 24'h123456, 0, 10, 2'd0, 1'b0);
    for (int f = 1; f < 6; f++) begin
      run_frame(2'd0, 24'h123456, f, (f == 5) ? 3 : -1, 2'd0, f == 5);
    end
    check_idle(2, 16'd6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
